// File: rtl/reg4_write_arb.sv
// reg4_write_arb: round-robin write arbiter and sequencer for a shared
// free-running register. Each transaction runs IDLE -> WRITE -> ACK. The
// register's d input is driven during WRITE and then held at the last
// written value.
//
// Optional build macro: REG4_WRITE_ARB_CLR_EN
//   Adds a clr input and a clr_done output. A clear writes zero through
//   the same three-state sequence, issues no ack and leaves the
//   round-robin pointer where it was.
//
// Parameter constraint: 2**IDX_W >= NUM_REQ, with NUM_REQ in 2..8.
module reg4_write_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,     // asynchronous, active low
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REG4_WRITE_ARB_CLR_EN
  input  logic                      clr,
  output logic                      clr_done,
`endif
  output logic [NUM_REQ-1:0]        ack,
  output logic [IDX_W-1:0]          gnt_idx,
  output logic                      busy,
  output logic [DATA_W-1:0]         reg_d
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [DATA_W-1:0]  reg_d_q,   reg_d_d;
  logic [NUM_REQ-1:0] ack_q,     ack_d;
  logic               busy_q,    busy_d;
`ifdef REG4_WRITE_ARB_CLR_EN
  // clr_op marks the in-flight transaction as a clear rather than a write.
  logic               clr_op_q,   clr_op_d;
  logic               clr_done_q, clr_done_d;
`endif

  // Requester indices in round-robin scan order starting at ptr, and the
  // request bits reordered the same way. The sum is one bit wider than
  // the index so a single conditional subtraction gives the wrap even
  // when NUM_REQ is not a power of two.
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;
  logic [DATA_W-1:0]  req_word [NUM_REQ];
  logic [NUM_REQ-1:0] ack_sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
    assign rot_idx[gi]  = (sum >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                          : sum[IDX_W-1:0];
    assign rot_req[gi]  = req[rot_idx[gi]];
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    // One-hot ack pattern for the current winner.
    assign ack_sel[gi]  = (gnt_idx_q == IDX_W'(gi));
  end

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [IDX_W-1:0]   ptr_inc;

  // Pick the first set request in scan order; the descending loop lets the
  // lowest scan offset overwrite later candidates.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_valid = 1'b1;
        win_idx   = rot_idx[i];
      end
    end
  end

  assign win_data = req_word[win_idx];

  // Pointer moves to the requester just after the one served, with wrap.
  assign ptr_inc = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                       : gnt_idx_q + IDX_W'(1);

  // Next-state and output computation for the IDLE/WRITE/ACK sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    reg_d_d   = reg_d_q;
    ack_d     = '0;
    busy_d    = busy_q;
`ifdef REG4_WRITE_ARB_CLR_EN
    clr_op_d   = clr_op_q;
    clr_done_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef REG4_WRITE_ARB_CLR_EN
        if (clr) begin
          // A clear beats every request; requests keep waiting.
          reg_d_d  = '0;
          busy_d   = 1'b1;
          clr_op_d = 1'b1;
          state_d  = ST_WRITE;
        end else if (win_valid) begin
`else
        if (win_valid) begin
`endif
          // Data is latched here, so later req/req_data changes
          // cannot disturb the write in flight.
          gnt_idx_d = win_idx;
          reg_d_d   = win_data;
          busy_d    = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The shared register captures reg_d on this edge.
`ifdef REG4_WRITE_ARB_CLR_EN
        if (clr_op_q) begin
          clr_done_d = 1'b1;
        end else begin
          ack_d = ack_sel;
        end
`else
        ack_d = ack_sel;
`endif
        state_d = ST_ACK;
      end
      ST_ACK: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef REG4_WRITE_ARB_CLR_EN
        if (!clr_op_q) begin
          ptr_d = ptr_inc;
        end
        clr_op_d = 1'b0;
`else
        ptr_d = ptr_inc;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      reg_d_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
`ifdef REG4_WRITE_ARB_CLR_EN
      clr_op_q   <= 1'b0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      reg_d_q    <= reg_d_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef REG4_WRITE_ARB_CLR_EN
      clr_op_q   <= clr_op_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign reg_d   = reg_d_q;
`ifdef REG4_WRITE_ARB_CLR_EN
  assign clr_done = clr_done_q;
`endif

endmodule

// File: tb/tb_reg4_write_arb.sv
// Testbench for reg4_write_arb: scenario tasks with a scoreboard queue of
// expected (winner, data) pairs, popped as grants/acks are observed.
module tb_reg4_write_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  gnt_idx;
  logic        busy;
  logic [3:0]  reg_d;
`ifdef REG4_WRITE_ARB_CLR_EN
  logic        clr;
  logic        clr_done;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];

  reg4_write_arb #(.NUM_REQ(4), .DATA_W(4), .IDX_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
`ifdef REG4_WRITE_ARB_CLR_EN
    .clr      (clr),
    .clr_done (clr_done),
`endif
    .ack      (ack),
    .gnt_idx  (gnt_idx),
    .busy     (busy),
    .reg_d    (reg_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive-only helper: pulse reset across one clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Wait (bounded) for any ack bit; returns whether seen and after how many negedges.
  task automatic wait_ack(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      cycles++;
      if (|ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    req = 4'b1111;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    repeat (3) @(negedge clk);
    vectors++; if (reg_d !== 4'h0) begin miscompares++; $display("FAIL rst_reg_d got=%h exp=0", reg_d); end
    vectors++; if (ack !== 4'h0) begin miscompares++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (gnt_idx !== 2'd0) begin miscompares++; $display("FAIL rst_gnt got=%0d exp=0", gnt_idx); end
    reset = 1'b1;
    sb.push_back('{idx: 2'd0, data: 4'h1});
    @(negedge clk);
    req = 4'b0000;
    e = sb.pop_front();
    vectors++; if (gnt_idx !== e.idx) begin miscompares++; $display("FAIL rst_first_gnt got=%0d exp=%0d", gnt_idx, e.idx); end
    vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL rst_first_data got=%h exp=%h", reg_d, e.data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_first_busy got=%b exp=1", busy); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL rst_first_ack got=%b exp=0001", ack); end
    $display("txn reset-first: idx=%0d data=%h", gnt_idx, reg_d);
    @(negedge clk);
    vectors++; if ({ack, busy} !== 5'b0) begin miscompares++; $display("FAIL rst_first_idle ack/busy got=%b exp=00000", {ack, busy}); end
  endtask

  task automatic test_single();
    exp_t e;
    req = 4'b0100;
    req_data = {4'h3, 4'hA, 4'h5, 4'h6};
    sb.push_back('{idx: 2'd2, data: 4'hA});
    @(negedge clk);
    vectors++; if (reg_d !== 4'hA) begin miscompares++; $display("FAIL single_reg_d got=%h exp=a", reg_d); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL single_early_ack got=%b exp=0000", ack); end
    @(negedge clk);
    e = sb.pop_front();
    vectors++; if (ack !== (4'b0001 << e.idx)) begin miscompares++; $display("FAIL single_ack got=%b exp=%b", ack, 4'b0001 << e.idx); end
    vectors++; if (gnt_idx !== e.idx) begin miscompares++; $display("FAIL single_gnt got=%0d exp=%0d", gnt_idx, e.idx); end
    $display("txn single: idx=%0d data=%h", gnt_idx, reg_d);
    req = 4'b0000;
    @(negedge clk);
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL single_ack_len got=%b exp=0000", ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_low got=%b exp=0", busy); end
    @(negedge clk);
    vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL single_hold got=%h exp=%h", reg_d, e.data); end
  endtask

  task automatic test_fairness();
    exp_t e;
    bit ok;
    int cyc;
    reset_pulse();
    req = 4'b1111;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 5; k++) sb.push_back('{idx: 2'(k % 4), data: 4'((k % 4) + 1)});
    for (int k = 0; k < 5; k++) begin
      wait_ack(6, ok, cyc);
      vectors++; if (!ok) begin miscompares++; $display("FAIL fair_timeout k=%0d got=no_ack exp=ack", k); end
      vectors++; if (cyc != ((k == 0) ? 2 : 3)) begin miscompares++; $display("FAIL fair_spacing k=%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 2 : 3); end
      e = sb.pop_front();
      vectors++; if (gnt_idx !== e.idx) begin miscompares++; $display("FAIL fair_gnt k=%0d got=%0d exp=%0d", k, gnt_idx, e.idx); end
      vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL fair_data k=%0d got=%h exp=%h", k, reg_d, e.data); end
      vectors++; if (ack !== (4'b0001 << e.idx)) begin miscompares++; $display("FAIL fair_ack k=%0d got=%b exp=%b", k, ack, 4'b0001 << e.idx); end
      $display("txn fairness: idx=%0d data=%h", gnt_idx, reg_d);
      if (k == 4) req = 4'b0000;
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fair_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_withdraw();
    exp_t e;
    req = 4'b0010;
    req_data = 16'h0070;
    sb.push_back('{idx: 2'd1, data: 4'h7});
    @(negedge clk);
    vectors++; if (gnt_idx !== 2'd1) begin miscompares++; $display("FAIL wd_gnt got=%0d exp=1", gnt_idx); end
    req = 4'b0000;
    req_data = 16'h00F0;
    @(negedge clk);
    e = sb.pop_front();
    vectors++; if (ack !== (4'b0001 << e.idx)) begin miscompares++; $display("FAIL wd_ack got=%b exp=%b", ack, 4'b0001 << e.idx); end
    vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL wd_data got=%h exp=%h", reg_d, e.data); end
    $display("txn withdraw: idx=%0d data=%h", gnt_idx, reg_d);
    @(negedge clk);
    vectors++; if ({ack, busy} !== 5'b0) begin miscompares++; $display("FAIL wd_idle ack/busy got=%b exp=00000", {ack, busy}); end
    vectors++; if (reg_d !== 4'h7) begin miscompares++; $display("FAIL wd_hold got=%h exp=7", reg_d); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    int cyc;
    req = 4'b0100;
    req_data = 16'h0500;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (reg_d !== 4'h0) begin miscompares++; $display("FAIL rm_async_reg_d got=%h exp=0", reg_d); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_async_busy got=%b exp=0", busy); end
    vectors++; if (gnt_idx !== 2'd0) begin miscompares++; $display("FAIL rm_async_gnt got=%0d exp=0", gnt_idx); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL rm_no_ack got=%b exp=0000", ack); end
    reset = 1'b1;
    req = 4'b1111;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    sb.push_back('{idx: 2'd0, data: 4'h1});
    wait_ack(4, ok, cyc);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rm_resume_timeout got=no_ack exp=ack"); end
    req = 4'b0000;
    e = sb.pop_front();
    vectors++; if (gnt_idx !== e.idx) begin miscompares++; $display("FAIL rm_resume_gnt got=%0d exp=%0d", gnt_idx, e.idx); end
    vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL rm_resume_data got=%h exp=%h", reg_d, e.data); end
    $display("txn reset-mid resume: idx=%0d data=%h", gnt_idx, reg_d);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    int cyc;
    // ptr is 1 here; requesters 3 and 0 pending, so 3 wins then wrap to 0.
    req = 4'b1001;
    req_data = 16'h900C;
    sb.push_back('{idx: 2'd3, data: 4'h9});
    sb.push_back('{idx: 2'd0, data: 4'hC});
    for (int k = 0; k < 2; k++) begin
      wait_ack(6, ok, cyc);
      vectors++; if (!ok || cyc != ((k == 0) ? 2 : 3)) begin miscompares++; $display("FAIL b2b_timing k=%0d got=%0d exp=%0d", k, ok ? cyc : -1, (k == 0) ? 2 : 3); end
      e = sb.pop_front();
      vectors++; if (gnt_idx !== e.idx) begin miscompares++; $display("FAIL b2b_gnt k=%0d got=%0d exp=%0d", k, gnt_idx, e.idx); end
      vectors++; if (reg_d !== e.data) begin miscompares++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, reg_d, e.data); end
      $display("txn back-to-back: idx=%0d data=%h", gnt_idx, reg_d);
      if (k == 1) req = 4'b0000;
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
  endtask

`ifdef REG4_WRITE_ARB_CLR_EN
  task automatic test_clr();
    exp_t e;
    bit ok;
    int cyc;
    clr = 1'b1;
    req = 4'b0010;
    req_data = 16'h00B0;
    sb.push_back('{idx: 2'd1, data: 4'hB});
    @(negedge clk);
    clr = 1'b0;
    vectors++; if (reg_d !== 4'h0) begin miscompares++; $display("FAIL clr_reg_d got=%h exp=0", reg_d); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clr_busy got=%b exp=1", busy); end
    @(negedge clk);
    vectors++; if (clr_done !== 1'b1) begin miscompares++; $display("FAIL clr_done got=%b exp=1", clr_done); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL clr_no_ack got=%b exp=0000", ack); end
    $display("txn clear: reg_d=%h", reg_d);
    @(negedge clk);
    vectors++; if ({clr_done, busy} !== 2'b00) begin miscompares++; $display("FAIL clr_end got=%b exp=00", {clr_done, busy}); end
    wait_ack(3, ok, cyc);
    vectors++; if (!ok) begin miscompares++; $display("FAIL clr_serve_timeout got=no_ack exp=ack"); end
    req = 4'b0000;
    e = sb.pop_front();
    vectors++; if (gnt_idx !== e.idx || reg_d !== e.data) begin miscompares++; $display("FAIL clr_serve got=%0d/%h exp=%0d/%h", gnt_idx, reg_d, e.idx, e.data); end
    $display("txn after-clear: idx=%0d data=%h", gnt_idx, reg_d);
    @(negedge clk);
    // After reset ptr=0; a clear must not move it, so requester 0 wins.
    reset_pulse();
    clr = 1'b1;
    req = 4'b1111;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    sb.push_back('{idx: 2'd0, data: 4'h1});
    @(negedge clk);
    clr = 1'b0;
    wait_ack(6, ok, cyc);
    req = 4'b0000;
    e = sb.pop_front();
    vectors++; if (!ok || gnt_idx !== e.idx) begin miscompares++; $display("FAIL clr_ptr got=%0d exp=%0d", gnt_idx, e.idx); end
    $display("txn clear-ptr: idx=%0d data=%h", gnt_idx, reg_d);
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b0;
    req = 4'b0000;
    req_data = 16'h0000;
`ifdef REG4_WRITE_ARB_CLR_EN
    clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_back_to_back();
`ifdef REG4_WRITE_ARB_CLR_EN
    test_clr();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
